mem_copy_master: RTL
====================

MEM_COPY_MASTER -- requirements
Module: mem_copy_master

Interface
REQ-001 The module SHALL have parameter LEN_W, default 16, giving the width of the word-count input and counter.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The module SHALL have port start, input, 1, a copy request sampled only in IDLE.
REQ-005 The module SHALL have port abort, input, 1, a stop request: transfer ends at the next word boundary.
REQ-006 The module SHALL have ports src_addr and dst_addr, each input, 32, byte addresses of the first source and destination word.
REQ-007 The module SHALL have port len_words, input, LEN_W, the number of 32-bit words to copy.
REQ-008 The module SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-009 The module SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-010 The module SHALL have port words_done, output, LEN_W, the count of words written in the current or last transfer.
REQ-011 The module SHALL have ports mem_valid (output, 1), mem_ready (input, 1), mem_addr (output, 32), mem_wdata (output, 32), mem_wstrb (output, 4) and mem_rdata (input, 32), forming the initiator side of the team valid/ready memory bus; wstrb 0000 is a read and 1111 is a word write.

Function
REQ-012 The module SHALL implement states IDLE, RD, RD_GAP, WR, WR_GAP and DONE.
REQ-013 In IDLE with start=1, it SHALL latch src, dst and len with bits [1:0] of both addresses forced to 00, clear words_done, and go to RD if len!=0, otherwise to DONE.
REQ-014 In RD it SHALL drive mem_valid=1, mem_addr=current src and mem_wstrb=0000, holding them stable until mem_ready is sampled 1.
REQ-015 On sampling mem_ready=1 in RD, it SHALL capture mem_rdata into a data register and go to RD_GAP.
REQ-016 In WR it SHALL drive mem_valid=1, mem_addr=current dst, mem_wdata=the data register and mem_wstrb=1111, holding them stable until mem_ready is sampled 1.
REQ-017 On sampling mem_ready=1 in WR, it SHALL increment src and dst by 4 (modulo 2^32 wrap), increment words_done, decrement the remaining count, and go to WR_GAP.
REQ-018 In RD_GAP and WR_GAP, mem_valid SHALL be 0 for exactly one cycle.
REQ-019 RD_GAP SHALL always go to WR.
REQ-020 WR_GAP SHALL go to DONE if the remaining count is 0 or abort is pending, otherwise to RD.
REQ-021 abort asserted in any non-IDLE state SHALL set a pending flag cleared on entry to IDLE.
REQ-022 abort SHALL never deassert mem_valid before mem_ready, and SHALL never cause a read to be left unwritten.
REQ-023 In DONE, done SHALL be 1 for exactly one cycle, after which the module goes to IDLE.
REQ-024 start outside IDLE SHALL be ignored.
REQ-025 In any state other than WR, mem_wstrb SHALL be 0000.
REQ-026 In IDLE, DONE and gap states, mem_addr SHALL hold its last value.
REQ-027 mem_ready sampled outside RD/WR SHALL be ignored.
REQ-028 A start sampled in the same cycle as DONE SHALL be ignored.
REQ-029 A start sampled in the first IDLE cycle after DONE SHALL be accepted.
REQ-030 src and dst ranges SHALL be allowed to overlap, with words copied strictly in ascending order.

Reset
REQ-031 Asserting reset SHALL immediately force state=IDLE, mem_valid=0, mem_wstrb=0000, busy=0, done=0, words_done=0, abort pending=0, and mem_addr, mem_wdata and the data register to 0, including mid-transaction.
REQ-032 After reset deasserts, no bus request SHALL be issued until a new start.

Verification
REQ-033 With the responder asserting ready 3 cycles after valid is first sampled, start at cycle t with src=0x100, dst=0x200, len=1 -> RD valid in t+1; read of 0x100; write of 0x200 with data mem[0x100]; done=1 in cycle t+11; words_done=1.
REQ-034 len=4, src=0x0, dst=0x40 -> 4 read/write pairs at ascending addresses; mem_valid=0 for exactly one cycle between requests; done once; words_done=4.
REQ-035 len=0 -> done pulses in cycle t+1 with no mem_valid activity and words_done=0.
REQ-036 len=8, abort pulsed during the 3rd read -> the 3rd write completes, then done; words_done=3; no 4th read.
REQ-037 reset asserted while RD is waiting for ready -> mem_valid=0 in the same cycle and all outputs at reset values; a later start with len=1 completes normally.
REQ-038 src=0xFFFFFFFC, len=2 with a responder that ignores the upper address bits -> the second read address is 0x00000000; start pulses while busy -> no effect.

Source files
------------

// File: rtl/mem_copy_master.sv
// Word-by-word memory copy engine: reads one source word, writes it to the destination, repeats.
// Every bus request is held until accepted and is followed by one idle cycle; abort stops at a word boundary.
module mem_copy_master #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] words_done,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_GAP,
        WR,
        WR_GAP,
        DONE
    } state_t;

    state_t           state;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [31:0]      rdata_q;
    logic [LEN_W-1:0] remain_q;
    logic             abort_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            rdata_q    <= '0;
            remain_q   <= '0;
            abort_pend <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            words_done <= '0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= 4'b0000;
        end else begin
            if (state != IDLE && abort) begin
                abort_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q      <= src_addr & 32'hFFFF_FFFC;
                        dst_q      <= dst_addr & 32'hFFFF_FFFC;
                        remain_q   <= len_words;
                        words_done <= '0;
                        busy       <= 1'b1;
                        if (len_words != '0) begin
                            state     <= RD;
                            mem_valid <= 1'b1;
                            mem_addr  <= src_addr & 32'hFFFF_FFFC;
                            mem_wstrb <= 4'b0000;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (mem_ready) begin
                        rdata_q   <= mem_rdata;
                        mem_valid <= 1'b0;
                        state     <= RD_GAP;
                    end
                end
                RD_GAP: begin
                    state     <= WR;
                    mem_valid <= 1'b1;
                    mem_addr  <= dst_q;
                    mem_wdata <= rdata_q;
                    mem_wstrb <= 4'b1111;
                end
                WR: begin
                    if (mem_ready) begin
                        mem_valid  <= 1'b0;
                        mem_wstrb  <= 4'b0000;
                        src_q      <= src_q + 32'd4;
                        dst_q      <= dst_q + 32'd4;
                        words_done <= words_done + 1'b1;
                        remain_q   <= remain_q - 1'b1;
                        state      <= WR_GAP;
                    end
                end
                WR_GAP: begin
                    // An abort arriving in this very cycle also stops before the next read.
                    if (remain_q == '0 || abort_pend || abort) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= RD;
                        mem_valid <= 1'b1;
                        mem_addr  <= src_q;
                        mem_wstrb <= 4'b0000;
                    end
                end
                DONE: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    abort_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    mem_valid <= 1'b0;
                    mem_wstrb <= 4'b0000;
                end
            endcase
        end
    end

endmodule
